// File: rtl/tdm_demux_1_8.sv
// tdm_demux_1_8: 1:8 TDM demultiplexer with frame_sync alignment, HUNT/LOCK framing and saturating error count
module tdm_demux_1_8 #(
  parameter int W    = 8,
  parameter int ERRW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [8*W-1:0]   dout,
  output logic [7:0]       ch_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err,
  output logic [ERRW-1:0]  err_cnt
);
  typedef enum logic {HUNT, LOCK} state_t;
  state_t          state_q, state_d;
  logic [2:0]      slot_q, slot_d, cap_slot;
  logic            cap, err, fd;
  logic [8*W-1:0]  dout_q;
  logic [7:0]      ch_valid_q;
  logic            frame_done_q, sync_err_q;
  logic [ERRW-1:0] err_cnt_q;
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    cap      = 1'b0;
    err      = 1'b0;
    fd       = 1'b0;
    cap_slot = slot_q;
    if (din_valid) begin
      if (frame_sync) begin
        // any sync restarts the frame at slot 0; only an early one is an error
        cap      = 1'b1;
        cap_slot = 3'd0;
        slot_d   = 3'd1;
        state_d  = LOCK;
        err      = (state_q == LOCK) && (slot_q != 3'd0);
      end else if (state_q == LOCK) begin
        if (slot_q == 3'd0) begin
          err     = 1'b1;
          state_d = HUNT;
        end else begin
          cap    = 1'b1;
          slot_d = slot_q + 3'd1;
          fd     = slot_q == 3'd7;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      dout_q       <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      ch_valid_q   <= cap ? (8'd1 << cap_slot) : 8'd0;
      frame_done_q <= fd;
      sync_err_q   <= err;
      if (err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERRW'(1);
      if (cap) dout_q[cap_slot*W +: W] <= din;
    end
  end
  assign dout       = dout_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign locked     = state_q == LOCK;
  assign sync_err   = sync_err_q;
  assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_tdm_demux_1_8.sv
// tb_tdm_demux_1_8: scoreboard bench; a frame-level model predicts each output event, a monitor compares
module tb_tdm_demux_1_8;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] din = '0;
  logic din_valid = 1'b0, frame_sync = 1'b0;
  logic [63:0] dout, dout2;
  logic [7:0] cv, cv2, ec;
  logic [1:0] ec2;
  logic fd, fd2, lk, lk2, se, se2;
  always #5 clk = ~clk;
  tdm_demux_1_8 dut (.clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .dout(dout), .ch_valid(cv), .frame_done(fd), .locked(lk), .sync_err(se), .err_cnt(ec));
  tdm_demux_1_8 #(.W(8), .ERRW(2)) dut2 (.clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .dout(dout2), .ch_valid(cv2), .frame_done(fd2), .locked(lk2),
    .sync_err(se2), .err_cnt(ec2));
  typedef struct { logic [7:0] cv; logic fd, se, lk; logic [63:0] dout; int errs; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  logic [7:0] ch [8];
  bit m_lock;
  int m_slot, m_errs;
  function automatic logic [63:0] pack();
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = ch[k];
    return r;
  endfunction
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic model(logic [7:0] d, logic fs);
    exp_t e;
    bit ev;
    ev = 0; e.cv = 0; e.fd = 0; e.se = 0;
    if (fs) begin
      e.se = m_lock && m_slot != 0;
      ch[0] = d; m_lock = 1; m_slot = 1; e.cv = 8'h01; ev = 1;
    end else if (m_lock && m_slot == 0) begin
      e.se = 1; m_lock = 0; ev = 1;
    end else if (m_lock) begin
      ch[m_slot] = d; e.cv = 8'd1 << m_slot; e.fd = m_slot == 7;
      m_slot = (m_slot + 1) % 8; ev = 1;
    end
    if (e.se) m_errs++;
    e.lk = m_lock; e.dout = pack(); e.errs = m_errs;
    if (ev) q.push_back(e);
  endtask
  task automatic drive(logic v, logic [7:0] d, logic fs);
    @(posedge clk); #2;
    din_valid = v; din = d; frame_sync = fs;
    if (v) model(d, fs);
  endtask
  task automatic idle(int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask
  task automatic do_reset();
    @(posedge clk); #2;
    din_valid = 0; frame_sync = 0;
    @(negedge clk); #1;
    rst = 1; #1;
    chk("rst_dout", dout, 0); chk("rst_ch_valid", cv, 0); chk("rst_frame_done", fd, 0);
    chk("rst_locked", lk, 0); chk("rst_sync_err", se, 0); chk("rst_err_cnt", ec, 0); chk("rst_err_cnt2", ec2, 0);
    for (int k = 0; k < 8; k++) ch[k] = 0;
    m_lock = 0; m_slot = 0; m_errs = 0;
    chk("queue_empty_at_reset", q.size(), 0);
    q.delete();
    @(posedge clk); #3;
    rst = 0;
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (cv !== 8'h00 || se !== 1'b0)) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output: ch_valid=%h sync_err=%b expected no output", cv, se);
      end else begin
        e = q.pop_front();
        chk("ch_valid", cv, e.cv); chk("frame_done", fd, e.fd); chk("sync_err", se, e.se);
        chk("locked", lk, e.lk); chk("dout", dout, e.dout);
        chk("err_cnt", ec, e.errs > 255 ? 255 : e.errs);
        chk("err_cnt_sat2", ec2, e.errs > 3 ? 3 : e.errs);
      end
    end
  end
  initial begin
    int gs;
    logic v, fs;
    do_reset();
    repeat (3) drive(1, 8'hAA, 0);
    for (int k = 0; k < 8; k++) drive(1, 8'h10 + 8'(k), k == 0);
    idle(2);
    chk("frame_dout", dout, 64'h1716151413121110); chk("frame_locked", lk, 1); chk("no_err_hunt", ec, 0);
    for (int k = 0; k < 8; k++) drive(1, 8'h60 + 8'(k), k == 0);
    for (int k = 0; k < 8; k++) begin drive(1, 8'h10 + 8'(k), k == 0); idle(2); end
    chk("gap_dout", dout, 64'h1716151413121110);
    drive(1, 8'h20, 1); drive(1, 8'h21, 0); drive(1, 8'h22, 0);
    drive(1, 8'h55, 1); drive(1, 8'h66, 0);
    idle(2);
    chk("early_ch0", dout[7:0], 8'h55); chk("early_ch1", dout[15:8], 8'h66); chk("early_err_cnt", ec, 1);
    for (int k = 2; k < 8; k++) drive(1, 8'h70 + 8'(k), 0);
    drive(1, 8'h99, 0);
    idle(2);
    chk("miss_locked", lk, 0); chk("miss_dout_hold", dout, pack()); chk("miss_err_cnt", ec, 2);
    drive(1, 8'h01, 1);
    repeat (5) begin drive(1, 8'h02, 0); drive(1, 8'h03, 1); end
    idle(2);
    chk("sat_err_cnt2", ec2, 3); chk("sat_err_cnt", ec, 7);
    for (int k = 0; k < 5; k++) drive(1, 8'h30 + 8'(k), k == 0);
    do_reset();
    drive(1, 8'h42, 0);
    idle(2);
    chk("post_rst_dout", dout, 0); chk("post_rst_locked", lk, 0);
    gs = 0;
    for (int i = 0; i < 600; i++) begin
      v = $urandom_range(0, 9) < 7;
      if (v) begin
        fs = (gs == 0) ^ ($urandom_range(0, 11) == 0);
        gs = fs ? 1 : (gs + 1) % 8;
      end else fs = 1'($urandom_range(0, 1));
      drive(v, 8'($urandom), fs);
    end
    idle(3);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
